// File: rtl/axi_burst_master_if.sv
// AXI4 master-side bundle for the burst master (AW/W/B/AR/R plus sideband tie-offs).
interface axi_burst_master_if #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 8
);
  logic [C_M_AXI_ID_WIDTH-1:0]       awid;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     awaddr;
  logic [7:0]                        awlen;
  logic [2:0]                        awsize;
  logic [1:0]                        awburst;
  logic                              awlock;
  logic [3:0]                        awcache;
  logic [2:0]                        awprot;
  logic [3:0]                        awqos;
  logic [3:0]                        awregion;
  logic                              awvalid;
  logic                              awready;
  logic [C_M_AXI_DATA_WIDTH-1:0]     wdata;
  logic [C_M_AXI_DATA_WIDTH/8-1:0]   wstrb;
  logic                              wlast;
  logic                              wvalid;
  logic                              wready;
  logic [C_M_AXI_ID_WIDTH-1:0]       bid;
  logic [1:0]                        bresp;
  logic                              bvalid;
  logic                              bready;
  logic [C_M_AXI_ID_WIDTH-1:0]       arid;
  logic [C_M_AXI_ADDR_WIDTH-1:0]     araddr;
  logic [7:0]                        arlen;
  logic [2:0]                        arsize;
  logic [1:0]                        arburst;
  logic                              arlock;
  logic [3:0]                        arcache;
  logic [2:0]                        arprot;
  logic [3:0]                        arqos;
  logic [3:0]                        arregion;
  logic                              arvalid;
  logic                              arready;
  logic [C_M_AXI_ID_WIDTH-1:0]       rid;
  logic [C_M_AXI_DATA_WIDTH-1:0]     rdata;
  logic [1:0]                        rresp;
  logic                              rlast;
  logic                              rvalid;
  logic                              rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_master.sv
// One-command-at-a-time AXI4 INCR burst master; write data is seed + beat index.
// Define RDATA_CHECK_EN to compare read beats against the pattern and count errors.
module axi_burst_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 8
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          w_rst,
  input  logic                          i_start,
  input  logic                          i_wr,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] i_addr,
  input  logic [7:0]                    i_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0] i_seed,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [1:0]                    o_bresp,
  output logic [C_M_AXI_DATA_WIDTH-1:0] o_rdata,
  output logic                          o_rdata_valid,
  output logic [8:0]                    o_rbeats,
  output logic [7:0]                    o_err_cnt,
  axi_burst_master_if.master            m_axi
);
  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;

  // state   | meaning
  // S_IDLE  | waiting for i_start
  // S_AW    | write address offered
  // S_W     | write beats streaming
  // S_B     | waiting for write response
  // S_AR    | read address offered
  // S_R     | read beats arriving
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   addr_q;
  logic [7:0]      len_q;
  logic [DW-1:0]   seed_q;
  logic [7:0]      beat_cnt;
  logic [7:0]      beat_inc;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs    = m_axi.awvalid && m_axi.awready;
  assign w_hs     = m_axi.wvalid  && m_axi.wready;
  assign b_hs     = m_axi.bvalid  && m_axi.bready;
  assign ar_hs    = m_axi.arvalid && m_axi.arready;
  assign r_hs     = m_axi.rvalid  && m_axi.rready;
  assign beat_inc = beat_cnt + 8'd1;

  assign m_axi.awid     = '0;
  assign m_axi.awaddr   = addr_q;
  assign m_axi.awlen    = len_q;
  assign m_axi.awsize   = 3'($clog2(DW/8));
  assign m_axi.awburst  = 2'b01;
  assign m_axi.awlock   = 1'b0;
  assign m_axi.awcache  = '0;
  assign m_axi.awprot   = '0;
  assign m_axi.awqos    = '0;
  assign m_axi.awregion = '0;
  assign m_axi.wstrb    = '1;
  assign m_axi.arid     = '0;
  assign m_axi.araddr   = addr_q;
  assign m_axi.arlen    = len_q;
  assign m_axi.arsize   = 3'($clog2(DW/8));
  assign m_axi.arburst  = 2'b01;
  assign m_axi.arlock   = 1'b0;
  assign m_axi.arcache  = '0;
  assign m_axi.arprot   = '0;
  assign m_axi.arqos    = '0;
  assign m_axi.arregion = '0;

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (i_start) state_nxt = i_wr ? S_AW : S_AR;
      S_AW:   if (aw_hs) state_nxt = S_W;
      S_W:    if (w_hs && m_axi.wlast) state_nxt = S_B;
      S_B:    if (b_hs) state_nxt = S_DONE;
      S_AR:   if (ar_hs) state_nxt = S_R;
      S_R:    if (r_hs && m_axi.rlast) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake strobes are decoded from the next state so every bus output is a flop.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      m_axi.awvalid <= 1'b0;
      m_axi.arvalid <= 1'b0;
      m_axi.wvalid  <= 1'b0;
      m_axi.wlast   <= 1'b0;
      m_axi.wdata   <= '0;
      m_axi.bready  <= 1'b0;
      m_axi.rready  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_bresp       <= 2'b00;
      o_rdata       <= '0;
      o_rdata_valid <= 1'b0;
      o_rbeats      <= '0;
      addr_q        <= '0;
      len_q         <= '0;
      seed_q        <= '0;
      beat_cnt      <= '0;
    end else begin
      m_axi.awvalid <= (state_nxt == S_AW);
      m_axi.arvalid <= (state_nxt == S_AR);
      m_axi.bready  <= (state_nxt == S_B);
      m_axi.rready  <= (state_nxt == S_R);
      o_busy        <= (state_nxt != S_IDLE);
      o_done        <= (state_nxt == S_DONE);
      o_rdata_valid <= r_hs;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            addr_q   <= i_addr;
            len_q    <= i_len;
            seed_q   <= i_seed;
            beat_cnt <= '0;
            if (!i_wr) o_rbeats <= '0;
          end
        end
        S_AW: begin
          if (aw_hs) begin
            m_axi.wvalid <= 1'b1;
            m_axi.wdata  <= seed_q;
            m_axi.wlast  <= (len_q == 8'd0);
          end
        end
        S_W: begin
          if (w_hs) begin
            if (m_axi.wlast) begin
              m_axi.wvalid <= 1'b0;
              m_axi.wlast  <= 1'b0;
            end else begin
              beat_cnt    <= beat_inc;
              m_axi.wdata <= seed_q + DW'(beat_inc);
              m_axi.wlast <= (beat_inc == len_q);
            end
          end
        end
        S_B: begin
          if (b_hs) o_bresp <= m_axi.bresp;
        end
        S_R: begin
          if (r_hs) begin
            o_rdata <= m_axi.rdata;
            if (o_rbeats != 9'h1FF) o_rbeats <= o_rbeats + 9'd1;
            if (beat_cnt != 8'hFF)  beat_cnt <= beat_inc;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RDATA_CHECK_EN
  logic [7:0] err_cnt;

  always_ff @(posedge S_AXI_ACLK) begin
    if (w_rst) begin
      err_cnt <= '0;
    end else if (state == S_IDLE && i_start && !i_wr) begin
      err_cnt <= '0;
    end else if (state == S_R && r_hs && err_cnt != 8'hFF &&
                 (m_axi.rdata != seed_q + DW'(beat_cnt) || m_axi.rresp != 2'b00)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

  assign o_err_cnt = err_cnt;
`else
  assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: behavioural AXI slave RAM with optional random stalls and scoreboards.
module tb_axi_burst_master;
  localparam int DW = 32;
  localparam int AW = 8;
`ifdef RDATA_CHECK_EN
  localparam int ERR_ON = 1;
`else
  localparam int ERR_ON = 0;
`endif

  logic          S_AXI_ACLK = 1'b0;
  logic          w_rst;
  logic          i_start, i_wr;
  logic [AW-1:0] i_addr;
  logic [7:0]    i_len;
  logic [DW-1:0] i_seed;
  logic          o_busy, o_done, o_rdata_valid;
  logic [1:0]    o_bresp;
  logic [DW-1:0] o_rdata;
  logic [8:0]    o_rbeats;
  logic [7:0]    o_err_cnt;

  axi_burst_master_if #(.C_M_AXI_ID_WIDTH(1), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) ax ();

  axi_burst_master #(.C_M_AXI_ID_WIDTH(1), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .w_rst(w_rst), .i_start(i_start), .i_wr(i_wr), .i_addr(i_addr),
    .i_len(i_len), .i_seed(i_seed), .o_busy(o_busy), .o_done(o_done), .o_bresp(o_bresp),
    .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid), .o_rbeats(o_rbeats),
    .o_err_cnt(o_err_cnt), .m_axi(ax)
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // stimulus/slave configuration shared with the slave model
  bit            rnd = 0;
  logic [1:0]    b_resp_val = 2'b00;
  logic [1:0]    r_resp_val = 2'b00;
  logic [AW-1:0] exp_addr;
  logic [7:0]    exp_len;
  logic [DW-1:0] wq[$];
  logic [DW-1:0] rq[$];
  int            aw_cnt = 0, ar_cnt = 0, w_cnt = 0;

  // slave state
  logic [DW-1:0] mem [256];
  logic [AW-1:0] aw_addr_s, r_addr;
  logic [8:0]    w_idx, r_idx;
  logic [7:0]    aw_len_s, r_len;
  bit            r_active, r_hold, b_wait, b_clear, aw_hold, w_hold, ar_hold;
  int            b_delay;
  logic [AW-1:0] aw_addr_h, ar_addr_h;
  logic [DW-1:0] wdata_h;
  logic          wlast_h;

  // Slave drives at the falling edge; values seen here are what the next rising edge samples.
  always @(negedge S_AXI_ACLK) begin
    if (w_rst) begin
      ax.awready = 0; ax.wready = 0; ax.bvalid = 0; ax.bresp = 0; ax.bid = 0;
      ax.arready = 0; ax.rvalid = 0; ax.rlast = 0; ax.rdata = 0; ax.rresp = 0; ax.rid = 0;
      r_active = 0; r_hold = 0; b_wait = 0; b_clear = 0; aw_hold = 0; w_hold = 0; ar_hold = 0;
      wq.delete(); rq.delete();
    end else begin
      if (aw_hold) begin
        check("awvalid_hold", ax.awvalid, 1);
        check("awaddr_stable", ax.awaddr, aw_addr_h);
      end
      if (ar_hold) begin
        check("arvalid_hold", ax.arvalid, 1);
        check("araddr_stable", ax.araddr, ar_addr_h);
      end
      if (w_hold) begin
        check("wvalid_hold", ax.wvalid, 1);
        check("wdata_stable", ax.wdata, wdata_h);
        check("wlast_stable", ax.wlast, wlast_h);
      end
      if (!ax.wvalid) check("wlast_idle", ax.wlast, 0);

      ax.awready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      ax.wready  = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      ax.arready = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
      if (b_clear) begin ax.bvalid = 0; b_clear = 0; end
      if (b_wait) begin
        if (b_delay == 0) begin ax.bvalid = 1; ax.bresp = b_resp_val; b_wait = 0; end
        else b_delay--;
      end
      if (r_active) begin
        ax.rvalid = r_hold || !rnd || ($urandom_range(0, 1) == 1);
        ax.rdata  = mem[8'(r_addr + r_idx)];
        ax.rlast  = (r_idx == {1'b0, r_len});
        ax.rresp  = r_resp_val;
      end else begin
        ax.rvalid = 0; ax.rlast = 0;
      end

      aw_hold = ax.awvalid && !ax.awready; aw_addr_h = ax.awaddr;
      if (ax.awvalid && ax.awready) begin
        check("awaddr", ax.awaddr, exp_addr);
        check("awlen", ax.awlen, exp_len);
        check("awsize", ax.awsize, 3'd2);
        check("awburst", ax.awburst, 2'b01);
        aw_addr_s = ax.awaddr; aw_len_s = ax.awlen; w_idx = 0; aw_cnt++;
      end
      w_hold = ax.wvalid && !ax.wready; wdata_h = ax.wdata; wlast_h = ax.wlast;
      if (ax.wvalid && ax.wready) begin
        check("wq_nonempty", wq.size() != 0, 1);
        if (wq.size() != 0) check("wdata", ax.wdata, wq.pop_front());
        check("wlast", ax.wlast, w_idx == {1'b0, aw_len_s});
        mem[8'(aw_addr_s + w_idx)] = ax.wdata;
        if (ax.wlast) begin b_wait = 1; b_delay = rnd ? $urandom_range(0, 3) : 0; end
        w_idx++; w_cnt++;
      end
      b_clear = ax.bvalid && ax.bready;
      ar_hold = ax.arvalid && !ax.arready; ar_addr_h = ax.araddr;
      if (ax.arvalid && ax.arready) begin
        check("araddr", ax.araddr, exp_addr);
        check("arlen", ax.arlen, exp_len);
        check("arsize", ax.arsize, 3'd2);
        r_active = 1; r_idx = 0; r_addr = ax.araddr; r_len = ax.arlen; ar_cnt++;
      end
      if (ax.rvalid && ax.rready) begin
        r_hold = 0; r_idx++;
        if (ax.rlast) r_active = 0;
      end else begin
        r_hold = ax.rvalid;
      end

      if (o_rdata_valid) begin
        check("rq_nonempty", rq.size() != 0, 1);
        if (rq.size() != 0) check("o_rdata", o_rdata, rq.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge S_AXI_ACLK);
    #1;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000 && !o_done; n++) step();
    check("done_seen", o_done, 1);
  endtask

  task automatic run_cmd(input bit wr, input logic [AW-1:0] addr, input logic [7:0] len,
                         input logic [DW-1:0] seed, input logic [DW-1:0] exp_base,
                         input logic [1:0] exp_resp, input logic [7:0] exp_err);
    exp_addr = addr; exp_len = len;
    for (int i = 0; i <= int'(len); i++) begin
      if (wr) wq.push_back(seed + DW'(i));
      else    rq.push_back(exp_base + DW'(i));
    end
    i_start = 1; i_wr = wr; i_addr = addr; i_len = len; i_seed = seed;
    step();
    i_start = 0;
    check("busy_after_start", o_busy, 1);
    check(wr ? "awvalid_latency" : "arvalid_latency", wr ? ax.awvalid : ax.arvalid, 1);
    wait_done();
    if (wr) begin
      check("o_bresp", o_bresp, exp_resp);
      check("wq_drained", wq.size(), 0);
    end else begin
      check("o_rbeats", o_rbeats, {1'b0, len} + 9'd1);
      check("o_err_cnt", o_err_cnt, exp_err);
      check("rq_drained", rq.size(), 0);
    end
    step();
    check("done_one_cycle", o_done, 0);
    check("busy_cleared", o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    int aw0, ar0, w0;
    w_rst = 1; i_start = 0; i_wr = 0; i_addr = 0; i_len = 0; i_seed = 0;
    repeat (3) step();
    check("rst_awvalid", ax.awvalid, 0);
    check("rst_wvalid", ax.wvalid, 0);
    check("rst_wlast", ax.wlast, 0);
    check("rst_arvalid", ax.arvalid, 0);
    check("rst_bready", ax.bready, 0);
    check("rst_rready", ax.rready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_bresp", o_bresp, 0);
    check("rst_rdata", o_rdata, 0);
    check("rst_rdata_valid", o_rdata_valid, 0);
    check("rst_rbeats", o_rbeats, 0);
    check("rst_err_cnt", o_err_cnt, 0);
    w_rst = 0;
    step();

    run_cmd(1, 8'h10, 8'd3, 32'hA000, 32'h0, 2'b00, 8'd0);
    run_cmd(0, 8'h10, 8'd3, 32'hA000, 32'hA000, 2'b00, 8'd0);
    run_cmd(0, 8'h10, 8'd3, 32'hB000, 32'hA000, 2'b00, ERR_ON ? 8'd4 : 8'd0);
    r_resp_val = 2'b10;
    run_cmd(0, 8'h10, 8'd3, 32'hA000, 32'hA000, 2'b00, ERR_ON ? 8'd4 : 8'd0);
    r_resp_val = 2'b00;

    rnd = 1;
    run_cmd(1, 8'h40, 8'd0, 32'h1234, 32'h0, 2'b00, 8'd0);
    run_cmd(0, 8'h40, 8'd0, 32'h1234, 32'h1234, 2'b00, 8'd0);
    b_resp_val = 2'b10;
    run_cmd(1, 8'h50, 8'd2, 32'h77, 32'h0, 2'b10, 8'd0);
    b_resp_val = 2'b00;
    run_cmd(1, 8'hF8, 8'd15, 32'hDEAD_FFF8, 32'h0, 2'b00, 8'd0);
    run_cmd(0, 8'hF8, 8'd15, 32'hDEAD_FFF8, 32'hDEAD_FFF8, 2'b00, 8'd0);

    // start strobes during a write must not launch a read
    aw0 = aw_cnt; ar0 = ar_cnt;
    exp_addr = 8'h80; exp_len = 8'd3;
    for (int i = 0; i < 4; i++) wq.push_back(32'h55 + DW'(i));
    i_start = 1; i_wr = 1; i_addr = 8'h80; i_len = 8'd3; i_seed = 32'h55;
    step();
    i_wr = 0; i_addr = 8'hF0;
    step();
    step();
    i_start = 0;
    wait_done();
    check("busy_ignore_ar", ar_cnt, ar0);
    check("busy_ignore_aw", aw_cnt, aw0 + 1);
    check("busy_ignore_wq", wq.size(), 0);
    step();
    check("busy_ignore_idle", o_busy, 0);

    // reset in the middle of an 8-beat write
    rnd = 0;
    w0 = w_cnt;
    exp_addr = 8'h20; exp_len = 8'd7;
    for (int i = 0; i < 8; i++) wq.push_back(32'h700 + DW'(i));
    i_start = 1; i_wr = 1; i_addr = 8'h20; i_len = 8'd7; i_seed = 32'h700;
    step();
    i_start = 0;
    for (int n = 0; n < 50 && w_cnt < w0 + 2; n++) step();
    check("rst_mid_reached", w_cnt, w0 + 2);
    w_rst = 1;
    step();
    check("rst_mid_awvalid", ax.awvalid, 0);
    check("rst_mid_wvalid", ax.wvalid, 0);
    check("rst_mid_wlast", ax.wlast, 0);
    check("rst_mid_bready", ax.bready, 0);
    check("rst_mid_arvalid", ax.arvalid, 0);
    check("rst_mid_busy", o_busy, 0);
    w_rst = 0;
    step();

    run_cmd(1, 8'h20, 8'd1, 32'h9000, 32'h0, 2'b00, 8'd0);
    run_cmd(0, 8'h20, 8'd1, 32'h9000, 32'h9000, 2'b00, 8'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
